pipe_scheduler: RTL

PIPE_SCHEDULER -- requirements
Module: pipe_scheduler

---
 rtl/pipe_scheduler.sv | 98 +++++++++
 1 files changed

// File: rtl/pipe_scheduler.sv
// pipe_scheduler: game-flow controller for a scrolling pipe game.
// Owns the IDLE/PLAY/OVER state machine, the scroll timebase, the
// pipe/gap column sequencer, the 3-bit pattern LFSR and the score.
//
// Output timing: every output is decoded from registered state only, so
// the bird/pipe inputs never reach an output combinationally.
//
// The bird_row and pipe_at_bird inputs are sampled only in a scroll cycle.
module pipe_scheduler #(
   parameter int TICK_DIV = 256,
   parameter int GAP_COLS = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [2:0] bird_row,
   input  logic [7:0] pipe_at_bird,
   output logic       active,
   output logic       gameover,
   output logic       scroll,
   output logic       emit_pipe,
   output logic [2:0] index,
   output logic [6:0] score
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      OVER = 2'd2
   } state_t;

   localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
   localparam logic [2:0]  COL_LAST  = 3'(GAP_COLS);
   localparam logic [6:0]  SCORE_MAX = 7'd99;

   state_t      state;
   logic [15:0] tick_cnt;
   logic [2:0]  col_cnt;
   logic [2:0]  lfsr;
   logic [6:0]  score_q;
   logic        hit;
   logic        pass;

   // Scroll/emit strobes and the collision/pass decision for this cycle.
   always_comb begin
      scroll    = (state == PLAY) && (tick_cnt == TICK_LAST);
      emit_pipe = scroll && (col_cnt == 3'd0);
      hit       = scroll && pipe_at_bird[bird_row];
      pass      = scroll && (pipe_at_bird != 8'd0) && !hit;
   end

   // Status outputs decoded from the state register alone.
   always_comb begin
      active   = (state == PLAY);
      gameover = (state == OVER);
      index    = lfsr;
      score    = score_q;
   end

   // Game FSM with its counters; starting a game clears timebase, column
   // phase and score, but the LFSR keeps running across games.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tick_cnt <= 16'd0;
         col_cnt  <= 3'd0;
         lfsr     <= 3'b001;
         score_q  <= 7'd0;
      end else begin
         case (state)
            IDLE, OVER: begin
               if (start) begin
                  state    <= PLAY;
                  tick_cnt <= 16'd0;
                  col_cnt  <= 3'd0;
                  score_q  <= 7'd0;
               end
            end
            PLAY: begin
               tick_cnt <= (tick_cnt == TICK_LAST) ? 16'd0 : tick_cnt + 16'd1;
               if (scroll) begin
                  col_cnt <= (col_cnt == COL_LAST) ? 3'd0 : col_cnt + 3'd1;
               end
               if (emit_pipe) begin
                  lfsr <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
               end
               if (hit) begin
                  state <= OVER;
               end else if (pass && (score_q != SCORE_MAX)) begin
                  score_q <= score_q + 7'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
